// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter.
// Converts an unsigned DATA_W-bit word into a 4-digit packed BCD word,
// one bit per clock. The result register only changes when a conversion
// completes, so the downstream 7-segment mux never sees partial values.
//
// Build option: define BCD_OVF_BLANK_EN to show values above 9999 as
// 16'hFFFF ("FFFF" on the display). Without it, such values saturate
// to 16'h9999. The ovf flag is raised in both builds.
module bin_to_bcd_seq #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       bcd,
  output logic              bcd_valid,
  output logic              ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

`ifdef BCD_OVF_BLANK_EN
  localparam logic [15:0] OVF_PATTERN = 16'hFFFF;
`else
  localparam logic [15:0] OVF_PATTERN = 16'h9999;
`endif

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_W - 1);

  logic [1:0]        state_q,     state_d;
  logic [DATA_W-1:0] binreg_q,    binreg_d;
  logic [19:0]       scratch_q,   scratch_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic [15:0]       bcd_q,       bcd_d;
  logic              ovf_q,       ovf_d;
  logic              bcdValid_q,  bcdValid_d;

  logic [19:0]       scratchAdj;
  logic              accept;

  // Double-dabble correction: every digit of 5 or more gets +3 so that
  // the following left shift carries it correctly into the next decade.
  // A digit is at most 9 here, so the 4-bit add never wraps.
  function automatic logic [19:0] addThree(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign in_ready   = (state_q == IDLE);
  assign accept     = in_valid && in_ready;
  assign scratchAdj = addThree(scratch_q);

  // Next-state logic for the control FSM and the conversion datapath.
  always_comb begin
    state_d    = state_q;
    binreg_d   = binreg_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    bcdValid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          binreg_d  = bin;
          scratch_d = 20'd0;
          count_d   = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        scratch_d = {scratchAdj[18:0], binreg_q[DATA_W-1]};
        binreg_d  = {binreg_q[DATA_W-2:0], 1'b0};
        count_d   = count_q + CNT_W'(1);
        if (count_q == LAST_COUNT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        ovf_d      = (scratch_q[19:16] != 4'd0);
        bcd_d      = ovf_d ? OVF_PATTERN : scratch_q[15:0];
        bcdValid_d = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion and clears
  // the visible result so no stale value survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      binreg_q   <= '0;
      scratch_q  <= 20'd0;
      count_q    <= '0;
      bcd_q      <= 16'h0000;
      ovf_q      <= 1'b0;
      bcdValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      binreg_q   <= binreg_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      bcdValid_q <= bcdValid_d;
    end
  end

  assign bcd       = bcd_q;
  assign ovf       = ovf_q;
  assign bcd_valid = bcdValid_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq (DATA_W=16).
// Expected results come from a decimal-arithmetic reference model.
// Compile with BCD_OVF_BLANK_EN defined to check the blanking build.
module tb_bin_to_bcd_seq;

  localparam int DATA_W = 16;
  localparam int LAT    = DATA_W + 1;

`ifdef BCD_OVF_BLANK_EN
  localparam logic [15:0] OVF_PAT = 16'hFFFF;
`else
  localparam logic [15:0] OVF_PAT = 16'h9999;
`endif

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] bin;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       bcd;
  logic              bcd_valid;
  logic              ovf;

  int testCount;
  int failCount;

  bin_to_bcd_seq #(.DATA_W(DATA_W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .ovf       (ovf)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: decimal digits by division, saturating/blanking above 9999.
  function automatic logic [15:0] refBcd(input int v);
    if (v > 9999) return OVF_PAT;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic refOvf(input int v);
    return (v > 9999);
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (assumes in_ready is high) and wait for the result.
  // lat counts edges after acceptance up to the first sample with bcd_valid;
  // readyLow counts samples with in_ready low; stable is cleared if bcd moves
  // before bcd_valid. Returns in the cycle where bcd_valid is high.
  task automatic applyStimulus(input logic [15:0] v, output logic [15:0] b,
                               output logic o, output int lat,
                               output int readyLow, output logic stable);
    logic [15:0] prevBcd;
    prevBcd  = bcd;
    stable   = 1'b1;
    lat      = -1;
    readyLow = 0;
    b        = 16'hxxxx;
    o        = 1'bx;
    bin      = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bin      = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      if (bcd_valid) begin
        lat = i;
        b   = bcd;
        o   = ovf;
        break;
      end
      if (!in_ready) readyLow++;
      if (bcd !== prevBcd) stable = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    bin      = '0;
    step();
    step();
    testCount++;
    if (bcd !== 16'h0000 || ovf !== 1'b0 || bcd_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got bcd=%h ovf=%b valid=%b expected 0000 0 0",
               bcd, ovf, bcd_valid);
    end
    #3 rst = 1'b0;
    step();
    testCount++;
    if (in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_zero_latency();
    logic [15:0] b;
    logic o, st;
    int lat, rl;
    applyStimulus(16'd0, b, o, lat, rl, st);
    testCount++;
    if (b !== 16'h0000 || o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL zero_value: got %h/%b expected 0000/0", b, o);
    end
    // Pulse occupies the 18th cycle after acceptance (after edge 17).
    testCount++;
    if (lat !== LAT) begin
      failCount++;
      $display("[TB] FAIL valid_latency: got %0d expected %0d", lat, LAT);
    end
    step();
    testCount++;
    if (bcd_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL valid_width: got %b expected 0", bcd_valid);
    end
  endtask

  task automatic test_1234();
    logic [15:0] b;
    logic o, st;
    int lat, rl;
    applyStimulus(16'd1234, b, o, lat, rl, st);
    testCount++;
    if (b !== 16'h1234 || o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL conv_1234: got %h/%b expected 1234/0", b, o);
    end
    testCount++;
    if (rl !== LAT) begin
      failCount++;
      $display("[TB] FAIL ready_low_cycles: got %0d expected %0d", rl, LAT);
    end
    testCount++;
    if (in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ready_at_valid: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b;
    logic o, st;
    int lat, rl;
    step();
    applyStimulus(16'd9999, b, o, lat, rl, st);
    testCount++;
    if (b !== 16'h9999 || o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_9999: got %h/%b expected 9999/0", b, o);
    end
    // Second request issued during the bcd_valid cycle.
    applyStimulus(16'd10000, b, o, lat, rl, st);
    testCount++;
    if (b !== OVF_PAT || o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_10000: got %h/%b expected %h/1", b, o, OVF_PAT);
    end
    testCount++;
    if (lat !== LAT || st !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_timing: got lat=%0d stable=%b expected %0d/1", lat, st, LAT);
    end
  endtask

  task automatic test_max_then_small();
    logic [15:0] b;
    logic o, st;
    int lat, rl;
    step();
    applyStimulus(16'd65535, b, o, lat, rl, st);
    testCount++;
    if (b !== OVF_PAT || o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL conv_65535: got %h/%b expected %h/1", b, o, OVF_PAT);
    end
    step();
    applyStimulus(16'd42, b, o, lat, rl, st);
    testCount++;
    if (b !== 16'h0042 || o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL conv_42: got %h/%b expected 0042/0", b, o);
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] first;
    int pulses;
    int lat;
    step();
    first    = 16'($urandom_range(0, 9999));
    bin      = first;
    in_valid = 1'b1;
    step();
    lat    = -1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bcd_valid) begin
        lat = i;
        in_valid = 1'b0;
        break;
      end
      bin = 16'($urandom);
      step();
    end
    testCount++;
    if (lat !== LAT || bcd !== refBcd(int'(first))) begin
      failCount++;
      $display("[TB] FAIL busy_result: got %h lat=%0d expected %h lat=%0d",
               bcd, lat, refBcd(int'(first)), LAT);
    end
    for (int i = 0; i < 25; i++) begin
      step();
      if (bcd_valid) pulses++;
    end
    testCount++;
    if (pulses !== 0) begin
      failCount++;
      $display("[TB] FAIL busy_extra_pulses: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bin      = 16'd5678;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    #1;
    testCount++;
    if (bcd !== 16'h0000 || bcd_valid !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL mid_reset: got bcd=%h valid=%b ovf=%b ready=%b expected 0000 0 0 1",
               bcd, bcd_valid, ovf, in_ready);
    end
    step();
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bcd_valid || bcd !== 16'h0000 || in_ready !== 1'b1) pulses++;
    end
    testCount++;
    if (pulses !== 0) begin
      failCount++;
      $display("[TB] FAIL mid_reset_stale: got %0d bad cycles expected 0", pulses);
    end
  endtask

  task automatic test_random();
    logic [15:0] b;
    logic o, st;
    int lat, rl;
    int v;
    for (int n = 0; n < 30; n++) begin
      v = (n % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) step();
      applyStimulus(16'(v), b, o, lat, rl, st);
      testCount++;
      if (b !== refBcd(v) || o !== refOvf(v) || lat !== LAT || st !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL random_%0d: bin=%0d got %h/%b lat=%0d stable=%b expected %h/%b lat=%0d",
                 n, v, b, o, lat, st, refBcd(v), refOvf(v), LAT);
      end
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    bin       = '0;
    test_reset();
    test_zero_latency();
    test_1234();
    test_back_to_back();
    test_max_then_small();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
